// File: rtl/scan_sequencer.sv
// Scan-chain load-and-run sequencer: streams program bytes MSB-first into a
// microcontroller scan chain, then runs the processor until it halts.
// Optional readback of the chain tail is enabled by defining SCAN_SEQUENCER_READBACK_EN.
module scan_sequencer #(
  parameter int CHAIN_LEN = 296
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       proc_en,
  input  logic       halt,
  output logic       busy,
  output logic       done,
  output logic       out_valid,
  output logic [7:0] out_data
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [15:0] CHAIN_LEN_W = 16'(CHAIN_LEN);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [15:0] bit_cnt;
  logic [7:0]  shift_byte;
  logic        last_bit;
  logic        byte_end;

  // The counter counts every shifted bit from zero, so its low three bits
  // double as the bit position inside the current byte.
  assign last_bit = (bit_cnt == CHAIN_LEN_W - 16'd1);
  assign byte_end = last_bit || (bit_cnt[2:0] == 3'd7);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path covered, so
    // no latch is inferred for state_next.
    state_next = state;
    case (state)
      ST_IDLE:  if (start)    state_next = ST_LOAD;
      ST_LOAD:  if (in_valid) state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (last_bit)      state_next = ST_RUN;
        else if (byte_end) state_next = ST_LOAD;
      end
      ST_RUN:   if (halt)     state_next = ST_DONE;
      ST_DONE:                state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= 16'd0;
      shift_byte <= 8'h00;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: bit_cnt <= 16'd0;
        ST_LOAD: if (in_valid) shift_byte <= in_data;
        ST_SHIFT: begin
          shift_byte <= {shift_byte[6:0], 1'b0};
          bit_cnt    <= bit_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are pure state decodes, so they all read zero the cycle after reset.
  assign in_ready    = (state == ST_LOAD);
  assign scan_enable = (state == ST_SHIFT);
  assign scan_in     = (state == ST_SHIFT) && shift_byte[7];
  assign proc_en     = (state == ST_RUN);
  assign busy        = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_RUN);
  assign done        = (state == ST_DONE);

`ifdef SCAN_SEQUENCER_READBACK_EN
  logic [7:0] rb_shift;
  logic [7:0] rb_next;
  logic [7:0] rb_data;
  logic       rb_valid;

  assign rb_next = {rb_shift[6:0], scan_out};

  always_ff @(posedge clk) begin
    if (!rst) begin
      rb_shift <= 8'h00;
      rb_data  <= 8'h00;
      rb_valid <= 1'b0;
    end else if (abort) begin
      rb_shift <= 8'h00;
      rb_valid <= 1'b0;
    end else if (state == ST_SHIFT) begin
      rb_valid <= byte_end;
      if (byte_end) begin
        // A short final byte is left-aligned; the vacated low bits are zero.
        rb_data  <= rb_next << (3'd7 - bit_cnt[2:0]);
        rb_shift <= 8'h00;
      end else begin
        rb_shift <= rb_next;
      end
    end else begin
      rb_valid <= 1'b0;
    end
  end

  assign out_valid = rb_valid;
  assign out_data  = rb_data;
`else
  logic unused_scan_out;

  assign unused_scan_out = scan_out;
  assign out_valid       = 1'b0;
  assign out_data        = 8'h00;
`endif

  bit_cnt_bounded: assert property (@(posedge clk) disable iff (!rst)
    bit_cnt <= CHAIN_LEN_W);

  scan_in_gated: assert property (@(posedge clk) disable iff (!rst)
    !scan_enable |-> !scan_in);

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer with a 12-bit behavioural scan chain.
// Expected scan bits, readback bytes and done pulses are queued by the stimulus.
module tb_scan_sequencer;

  localparam int CL = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          scan_enable;
  logic          scan_in;
  logic          scan_out;
  logic          proc_en;
  logic          halt;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic [7:0]    out_data;

  logic [CL-1:0] chain = '0;
  logic          preload;

  int            n_checks = 0;
  int            n_fail   = 0;
  bit            exp_bits[$];
  logic [7:0]    exp_rb[$];
  int            exp_done = 0;
  bit            mon_bit;
  logic [7:0]    mon_byte;

  scan_sequencer #(.CHAIN_LEN(CL)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .scan_enable(scan_enable),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .proc_en    (proc_en),
    .halt       (halt),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  assign scan_out = chain[CL-1];

  always @(posedge clk) begin
    if (preload)          chain <= 12'hABC;
    else if (scan_enable) chain <= {chain[CL-2:0], scan_in};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    if (scan_enable) begin
      check("scan_bit_expected", 32'(exp_bits.size() != 0), 1);
      if (exp_bits.size() != 0) begin
        mon_bit = exp_bits.pop_front();
        check("scan_in", 32'(scan_in), 32'(mon_bit));
      end
    end else begin
      check("scan_in_gated", 32'(scan_in), 0);
    end
    if (done) begin
      check("done_expected", 32'(exp_done > 0), 1);
      if (exp_done > 0) exp_done--;
      check("done_proc_en", 32'(proc_en), 0);
    end
`ifdef SCAN_SEQUENCER_READBACK_EN
    if (out_valid) begin
      check("rb_expected", 32'(exp_rb.size() != 0), 1);
      if (exp_rb.size() != 0) begin
        mon_byte = exp_rb.pop_front();
        check("out_data", 32'(out_data), 32'(mon_byte));
      end
    end
`else
    check("readback_off", 32'({out_valid, out_data}), 0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input int n);
    logic [11:0] pat;
    pat = 12'hA5F;
    for (int i = 11; i > 11 - n; i--) exp_bits.push_back(pat[i]);
  endtask

  task automatic push_rb(input logic [7:0] b);
`ifdef SCAN_SEQUENCER_READBACK_EN
    exp_rb.push_back(b);
`else
    if (b == 8'hFF) $display("readback byte 0x%0h not modelled", b);
`endif
  endtask

  task automatic do_start();
    preload = 1'b1;
    start   = 1'b1;
    tick();
    preload = 1'b0;
    start   = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    check("in_ready_in_load", 32'(in_ready), 1);
  endtask

  task automatic send(input logic [7:0] b);
    int k;
    bit acc;
    k        = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      acc = in_ready;
      tick();
      k++;
    end while (!acc && k < 50);
    check("send_accepted", 32'(acc), 1);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check("wait_in_ready", 32'(in_ready), 1);
  endtask

  task automatic wait_run();
    int k;
    k = 0;
    while (!proc_en && k < 100) begin
      tick();
      k++;
    end
    check("proc_en_in_run", 32'(proc_en), 1);
    check("busy_in_run", 32'(busy), 1);
    check("chain_loaded", 32'(chain), 32'h0A5F);
    check("bits_consumed", 32'(exp_bits.size()), 0);
  endtask

  task automatic halt_run();
    tick();
    check("proc_en_held", 32'(proc_en), 1);
    exp_done++;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("done_n1", 32'(done), 1);
    check("proc_en_n1", 32'(proc_en), 0);
    check("busy_n1", 32'(busy), 0);
    tick();
    check("done_n2", 32'(done), 0);
    check("busy_n2", 32'(busy), 0);
    check("idle_n2_in_ready", 32'(in_ready), 0);
  endtask

  task automatic full_run();
    push_bits(12);
    push_rb(8'hAB);
    push_rb(8'hC0);
    do_start();
    send(8'hA5);
    send(8'hF0);
    in_valid = 1'b0;
    wait_run();
    halt_run();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    halt     = 1'b0;
    preload  = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 32'({in_ready, scan_enable, scan_in, proc_en, busy, done,
                                out_valid, out_data}), 0);
    rst   = 1'b1;
    start = 1'b0;
    tick();
    check("idle_after_reset", 32'(busy), 0);

    // Back-to-back bytes with in_valid held.
    full_run();

    // Five-cycle in_valid gap while waiting for the second byte.
    push_bits(12);
    push_rb(8'hAB);
    push_rb(8'hC0);
    do_start();
    send(8'hA5);
    in_valid = 1'b0;
    wait_ready();
    for (int g = 0; g < 5; g++) begin
      check("gap_in_ready", 32'(in_ready), 1);
      check("gap_scan_enable", 32'(scan_enable), 0);
      tick();
    end
    send(8'hF0);
    in_valid = 1'b0;
    wait_run();
    halt_run();

    // Abort in the third SHIFT cycle of the second byte.
    push_bits(11);
    push_rb(8'hAB);
    do_start();
    send(8'hA5);
    send(8'hF0);
    in_valid = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_scan_enable", 32'(scan_enable), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_proc_en", 32'(proc_en), 0);
    repeat (4) tick();
    check("abort_bits_consumed", 32'(exp_bits.size()), 0);
    check("abort_no_done", 32'(exp_done), 0);

    // A fresh start after abort repeats the normal sequence.
    full_run();

    // start together with abort in IDLE stays in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);
    check("start_abort_in_ready", 32'(in_ready), 0);
    tick();
    check("start_abort_idle", 32'(busy), 0);

    // Reset pulse during RUN, with start held while reset is low.
    push_bits(12);
    push_rb(8'hAB);
    push_rb(8'hC0);
    do_start();
    send(8'hA5);
    send(8'hF0);
    in_valid = 1'b0;
    wait_run();
    tick();
    rst   = 1'b0;
    start = 1'b1;
    tick();
    rst   = 1'b1;
    start = 1'b0;
    check("run_reset_outputs", 32'({in_ready, scan_enable, scan_in, proc_en, busy, done,
                                    out_valid, out_data}), 0);
    tick();
    check("run_reset_idle", 32'(busy), 0);
    check("run_reset_proc_en", 32'(proc_en), 0);

    repeat (3) tick();
    check("final_bits_empty", 32'(exp_bits.size()), 0);
    check("final_rb_empty", 32'(exp_rb.size()), 0);
    check("final_done_empty", 32'(exp_done), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
